regfile_write_sched: RTL

Write-port controller for the 32x32 register file. It initialises the file by zeroing all 32 entries after reset or on a clear request. After that it shares the single write port (`WE3`/`A3`/`WD3`) between the core writeback path and a debug/loader requester, using valid/ready handshakes. It sits between the writeback stage, the debug port and the register file.

---
 rtl/regfile_write_sched_if.sv | 36 +++
 rtl/regfile_write_sched.sv | 121 ++++++++++++
 2 files changed

// File: rtl/regfile_write_sched_if.sv
// Write-side bundle for regfile_write_sched: writeback and debug valid/ready
// requesters plus the registered WE3/A3/WD3 register-file write port.
interface regfile_write_sched_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_ready;

    logic          dbg_valid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          dbg_ready;

    logic          WE3;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;

    modport master (
        output wb_valid, wb_addr, wb_data,
        input  wb_ready,
        output dbg_valid, dbg_addr, dbg_data,
        input  dbg_ready,
        input  WE3, A3, WD3
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        output wb_ready,
        input  dbg_valid, dbg_addr, dbg_data,
        output dbg_ready,
        output WE3, A3, WD3
    );
endinterface

// File: rtl/regfile_write_sched.sv
// Register-file write-port scheduler: zeroing sweep after reset/clr, then wb vs dbg arbitration.
// Define REGFILE_SCHED_RR_EN for round-robin arbitration instead of fixed wb-over-dbg priority.
module regfile_write_sched #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    regfile_write_sched_if.slave bus,
    output logic                 init_done
);

    typedef enum logic {INIT, RUN} state_t;

    state_t        state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic [AW-1:0] a3_q, a3_n;
    logic [DW-1:0] wd3_q, wd3_n;
    logic          we3_q, we3_n;
    logic          done_n;
    logic          grant_wb, grant_dbg;
    logic          wb_fire, dbg_fire;

`ifdef REGFILE_SCHED_RR_EN
    // last_dbg=1 means dbg won the most recent transfer, so wb wins the next tie
    logic last_dbg, last_dbg_n;

    always_comb begin
        grant_wb  = ~bus.dbg_valid | last_dbg;
        grant_dbg = ~bus.wb_valid | ~last_dbg;
    end

    always_comb begin
        last_dbg_n = last_dbg;
        if (wb_fire)
            last_dbg_n = 1'b0;
        else if (dbg_fire)
            last_dbg_n = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_dbg <= 1'b1;
        else
            last_dbg <= last_dbg_n;
    end
`else
    assign grant_wb  = 1'b1;
    assign grant_dbg = ~bus.wb_valid;
`endif

    assign bus.wb_ready  = (state == RUN) && !clr && grant_wb;
    assign bus.dbg_ready = (state == RUN) && !clr && grant_dbg;
    assign wb_fire       = bus.wb_valid && bus.wb_ready;
    assign dbg_fire      = bus.dbg_valid && bus.dbg_ready;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        we3_n   = 1'b0;
        a3_n    = a3_q;
        wd3_n   = wd3_q;
        done_n  = init_done;
        if (clr) begin
            state_n = INIT;
            cnt_n   = '0;
            done_n  = 1'b0;
        end else begin
            case (state)
                INIT: begin
                    we3_n = 1'b1;
                    a3_n  = cnt;
                    wd3_n = '0;
                    cnt_n = cnt + AW'(1);
                    if (cnt == AW'(NREG - 1)) begin
                        state_n = RUN;
                        done_n  = 1'b1;
                    end
                end
                RUN: begin
                    // x0 is hardwired zero: accept the request but suppress the write
                    if (wb_fire) begin
                        we3_n = (bus.wb_addr != '0);
                        a3_n  = bus.wb_addr;
                        wd3_n = bus.wb_data;
                    end else if (dbg_fire) begin
                        we3_n = (bus.dbg_addr != '0);
                        a3_n  = bus.dbg_addr;
                        wd3_n = bus.dbg_data;
                    end
                end
                default: state_n = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            we3_q     <= 1'b0;
            a3_q      <= '0;
            wd3_q     <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            we3_q     <= we3_n;
            a3_q      <= a3_n;
            wd3_q     <= wd3_n;
            init_done <= done_n;
        end
    end

    assign bus.WE3 = we3_q;
    assign bus.A3  = a3_q;
    assign bus.WD3 = wd3_q;

endmodule
